deco_stage: RTL and testbench

Parametrised, pipelined instruction-decode stage with integrated register file. Accepts one 32-bit instruction per cycle over a valid/ready handshake, reads operands, and presents a registered decoded bundle to execute one cycle later. A writeback port updates the register file. It sits between fetch and execute and replaces the earlier combinational decoder.

---
 rtl/deco_pkg.sv | 102 ++++++++++
 rtl/deco_regfile.sv | 49 ++++
 rtl/deco_stage.sv | 128 ++++++++++++
 tb/tb_deco_stage.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deco_pkg.sv
// -----------------------------------------------------------------------------
// deco_pkg
// Shared definitions for the instruction-decode stage:
//   - deco_op_e     : defined opcodes (everything else decodes as illegal)
//   - field constants: bit positions of the opcode / a / b / c fields
//   - deco_bundle_t : fixed-width control part of the decoded bundle
//                     (opcode, zero-extended immediate source, we, illegal);
//                     the parameter-sized parts (rd, operands) travel beside it
//   - deco_ctl_t    : bundle plus operand/destination selects
//   - deco_decode() : opcode table -> deco_ctl_t
// No ports; no configuration macros.
// -----------------------------------------------------------------------------
package deco_pkg;

  typedef enum logic [4:0] {
    OP_LV  = 5'd1,
    OP_ADD = 5'd2,
    OP_SUB = 5'd3,
    OP_AND = 5'd4,
    OP_OR  = 5'd5,
    OP_CP  = 5'd6,
    OP_B   = 5'd7,
    OP_BEQ = 5'd8,
    OP_SLR = 5'd9,
    OP_GP  = 5'd10
  } deco_op_e;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int OPC_W   = 5;
  localparam int FA_LSB  = 18;
  localparam int FB_LSB  = 9;
  localparam int FC_LSB  = 0;
  localparam int FIELD_W = 9;
  localparam int IMM_W   = 20;  // widest immediate any opcode carries

  // Which instruction field feeds a register-file read port.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2,
    SRC_C    = 2'd3
  } deco_src_e;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [IMM_W-1:0] imm;
    logic             we;
    logic             illegal;
  } deco_bundle_t;

  typedef struct packed {
    deco_bundle_t bnd;
    logic         rd_en;   // out_rd carries field a
    deco_src_e    rs_src;
    deco_src_e    rt_src;
  } deco_ctl_t;

  function automatic deco_ctl_t deco_decode(input logic [INSTR_W-1:0] instr);
    deco_ctl_t c;
    c            = '0;
    c.bnd.opcode = instr[OPC_MSB:OPC_LSB];
    case (instr[OPC_MSB:OPC_LSB])
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        c.rd_en  = 1'b1;
        c.rs_src = SRC_B;
        c.rt_src = SRC_C;
        c.bnd.we = 1'b1;
      end
      OP_LV, OP_CP: begin
        c.rd_en   = 1'b1;
        c.bnd.imm = instr[19:0];
        c.bnd.we  = 1'b1;
      end
      OP_B: begin
        c.bnd.imm = {13'd0, instr[6:0]};
      end
      OP_BEQ: begin
        c.rs_src  = SRC_A;
        c.rt_src  = SRC_B;
        c.bnd.imm = {11'd0, instr[8:0]};
      end
      OP_SLR: begin
        c.rd_en   = 1'b1;
        c.rs_src  = SRC_A;
        c.bnd.imm = instr[19:0];
        c.bnd.we  = 1'b1;
      end
      OP_GP: begin
        c.bnd.imm = {2'd0, instr[17:0]};
      end
      default: begin
        // Undefined opcode: everything zero except the illegal flag.
        c             = '0;
        c.bnd.illegal = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/deco_regfile.sv
// -----------------------------------------------------------------------------
// deco_regfile
// NUM_REGS x DATA_W register file, cleared by asynchronous reset.
// One write port, two combinational read ports.
// Macro DECO_BYPASS_EN: when defined, a same-cycle write to an index being
// read is forwarded to that read port; otherwise reads return the pre-write
// value and the new value is visible from the next cycle.
// Ports:
//   clock, reset (async active-low)
//   wb_en / wb_idx / wb_data : write port
//   ra_idx -> ra_data, rb_idx -> rb_data : read ports
// -----------------------------------------------------------------------------
module deco_regfile
  import deco_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [IDX_W-1:0]  ra_idx,
  output logic [DATA_W-1:0] ra_data,
  input  logic [IDX_W-1:0]  rb_idx,
  output logic [DATA_W-1:0] rb_data
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (wb_en) begin
      mem_q[wb_idx] <= wb_data;
    end
  end

`ifdef DECO_BYPASS_EN
  assign ra_data = (wb_en && (wb_idx == ra_idx)) ? wb_data : mem_q[ra_idx];
  assign rb_data = (wb_en && (wb_idx == rb_idx)) ? wb_data : mem_q[rb_idx];
`else
  assign ra_data = mem_q[ra_idx];
  assign rb_data = mem_q[rb_idx];
`endif

endmodule

// File: rtl/deco_stage.sv
// -----------------------------------------------------------------------------
// deco_stage
// Pipelined decode stage: accepts one instruction per cycle on a valid/ready
// handshake, reads operands from the integrated register file and presents a
// registered decoded bundle one cycle later.
// Macro DECO_BYPASS_EN (see deco_regfile): write-to-read forwarding.
// Ports:
//   clock, reset (async active-low)
//   in_valid/in_instr/in_ready : instruction input handshake
//   flush                      : drop held and incoming instruction
//   wb_en/wb_idx/wb_data       : register-file writeback
//   out_valid/out_ready        : bundle output handshake
//   out_opcode, out_rd, out_rs_val, out_rt_val, out_imm, out_we, out_illegal
// -----------------------------------------------------------------------------
module deco_stage
  import deco_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_opcode,
  output logic [IDX_W-1:0]  out_rd,
  output logic [DATA_W-1:0] out_rs_val,
  output logic [DATA_W-1:0] out_rt_val,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_we,
  output logic              out_illegal
);

  deco_ctl_t         ctl;
  logic [IDX_W-1:0]  idx_a, idx_b, idx_c;
  logic [IDX_W-1:0]  ra_idx, rb_idx;
  logic [DATA_W-1:0] ra_data, rb_data;
  logic              accept;

  logic [DATA_W-1:0] rs_d, rt_d;
  logic [IDX_W-1:0]  rd_d;

  logic              valid_q;
  deco_bundle_t      bnd_q;
  logic [IDX_W-1:0]  rd_q;
  logic [DATA_W-1:0] rs_q, rt_q;

  // Not every instruction bit reaches a register for every NUM_REGS.
  logic unused_instr;
  assign unused_instr = ^in_instr;

  // Decode (combinational, from in_instr only)
  assign ctl   = deco_decode(in_instr);
  assign idx_a = in_instr[FA_LSB +: IDX_W];
  assign idx_b = in_instr[FB_LSB +: IDX_W];
  assign idx_c = in_instr[FC_LSB +: IDX_W];

  // Port A serves rs (field b for arith, field a for BEQ/SLR);
  // port B serves rt (field c for arith, field b for BEQ).
  always_comb begin
    ra_idx = idx_b;
    if (ctl.rs_src == SRC_A) ra_idx = idx_a;
  end
  assign rb_idx = (ctl.rt_src == SRC_B) ? idx_b : idx_c;

  deco_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .wb_en  (wb_en),
    .wb_idx (wb_idx),
    .wb_data(wb_data),
    .ra_idx (ra_idx),
    .ra_data(ra_data),
    .rb_idx (rb_idx),
    .rb_data(rb_data)
  );

  assign rs_d = (ctl.rs_src == SRC_NONE) ? '0 : ra_data;
  assign rt_d = (ctl.rt_src == SRC_NONE) ? '0 : rb_data;
  assign rd_d = ctl.rd_en ? idx_a : '0;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register: the bundle changes only on an accepted, unflushed
  // instruction, so it is stable for the whole of a stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      bnd_q   <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
    end else begin
      if (flush)          valid_q <= 1'b0;
      else if (accept)    valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;

      if (accept && !flush) begin
        bnd_q <= ctl.bnd;
        rd_q  <= rd_d;
        rs_q  <= rs_d;
        rt_q  <= rt_d;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_opcode  = bnd_q.opcode;
  assign out_rd      = rd_q;
  assign out_rs_val  = rs_q;
  assign out_rt_val  = rt_q;
  assign out_imm     = DATA_W'(bnd_q.imm);
  assign out_we      = bnd_q.we;
  assign out_illegal = bnd_q.illegal;

endmodule

// File: tb/tb_deco_stage.sv
module tb_deco_stage;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;

  logic              clock, reset;
  logic              in_valid, in_ready, flush;
  logic [31:0]       in_instr;
  logic              wb_en;
  logic [IDX_W-1:0]  wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid, out_ready;
  logic [4:0]        out_opcode;
  logic [IDX_W-1:0]  out_rd;
  logic [DATA_W-1:0] out_rs_val, out_rt_val, out_imm;
  logic              out_we, out_illegal;

  deco_stage #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd),
    .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_imm(out_imm),
    .out_we(out_we), .out_illegal(out_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [4:0]        opc;
    logic [IDX_W-1:0]  rd;
    logic [DATA_W-1:0] rs, rt, imm;
    logic              we, ill;
  } bnd_t;

  int nvec = 0;
  int nerr = 0;
  bit bypass;

  // Reference state: register contents and the bundle execute should see.
  logic [DATA_W-1:0] mreg [NUM_REGS];
  logic              e_valid;
  bnd_t              e_b;

  function automatic bnd_t got_b();
    return {out_opcode, out_rd, out_rs_val, out_rt_val, out_imm, out_we, out_illegal};
  endfunction

  function automatic logic [DATA_W-1:0] rd_op(int idx);
    if (bypass && wb_en && (int'(wb_idx) == idx)) return wb_data;
    return mreg[idx];
  endfunction

  function automatic bnd_t model_decode(logic [31:0] ins);
    bnd_t r;
    int op, a, b, c;
    r  = '0;
    op = int'(ins[31:27]);
    a  = int'(ins[26:18]) % NUM_REGS;
    b  = int'(ins[17:9]) % NUM_REGS;
    c  = int'(ins[8:0]) % NUM_REGS;
    r.opc = 5'(op);
    case (op)
      2, 3, 4, 5: begin r.rd = IDX_W'(a); r.rs = rd_op(b); r.rt = rd_op(c); r.we = 1; end
      1, 6:       begin r.rd = IDX_W'(a); r.imm = ins & 32'h000F_FFFF; r.we = 1; end
      7:          r.imm = ins & 32'h0000_007F;
      8:          begin r.rs = rd_op(a); r.rt = rd_op(b); r.imm = ins & 32'h0000_01FF; end
      9:          begin r.rd = IDX_W'(a); r.rs = rd_op(a); r.imm = ins & 32'h000F_FFFF; r.we = 1; end
      10:         r.imm = ins & 32'h0003_FFFF;
      default:    begin r = '0; r.ill = 1; end
    endcase
    return r;
  endfunction

  // Advance the reference model over one clock edge using the current inputs,
  // then let the DUT take the same edge.
  task automatic tick();
    logic acc;
    acc = in_valid && (!e_valid || out_ready);
    if (flush)          e_valid = 1'b0;
    else if (acc)       begin e_valid = 1'b1; e_b = model_decode(in_instr); end
    else if (out_ready) e_valid = 1'b0;
    if (wb_en) mreg[wb_idx] = wb_data;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid  = 0; in_instr = '0; flush = 0;
    wb_en     = 0; wb_idx = '0; wb_data = '0; out_ready = 1;
  endtask

  task automatic model_clear();
    e_valid = 0; e_b = '0;
    for (int i = 0; i < NUM_REGS; i++) mreg[i] = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    #3 reset = 0;
    model_clear();
    #10;
    nvec++;
    if ({out_valid, got_b()} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got v=%0b b=%h want all zero", out_valid, got_b());
    end
    @(negedge clock) reset = 1;
    @(posedge clock); #1;
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ready: got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_arith();
    wb_en = 1; wb_idx = 3; wb_data = 5; tick();
    wb_idx = 4; wb_data = 7; tick();
    wb_en = 0;
    in_valid = 1; in_instr = {5'd2, 9'd1, 9'd3, 9'd4}; tick();
    in_valid = 0;
    nvec++;
    if (!(out_valid === 1 && out_rd === 1 && out_rs_val === 5 && out_rt_val === 7 &&
          out_we === 1 && out_illegal === 0 && out_opcode === 2 && out_imm === 0)) begin
      nerr++;
      $display("FAIL arith_add: got v=%0b rd=%0d rs=%0d rt=%0d we=%0b want 1 1 5 7 1",
               out_valid, out_rd, out_rs_val, out_rt_val, out_we);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL arith_drain: got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_lv_illegal();
    in_valid = 1; in_instr = {5'd1, 7'h55, 20'hABCDE}; tick();
    nvec++;
    if (!(out_valid === 1 && out_imm === 32'h000ABCDE && out_rs_val === 0 &&
          out_rt_val === 0 && out_we === 1 && out_illegal === 0 && got_b() === e_b)) begin
      nerr++;
      $display("FAIL lv: got v=%0b imm=%h rs=%h rt=%h we=%0b want 1 000abcde 0 0 1",
               out_valid, out_imm, out_rs_val, out_rt_val, out_we);
    end
    in_instr = {5'h1F, 27'h5A5A5A5}; tick();
    in_valid = 0;
    nvec++;
    if (!(out_valid === 1 && out_illegal === 1 && out_we === 0 && out_imm === 0 &&
          out_rd === 0 && out_rs_val === 0 && out_rt_val === 0)) begin
      nerr++;
      $display("FAIL illegal: got v=%0b ill=%0b we=%0b b=%h want 1 1 0", out_valid,
               out_illegal, out_we, got_b());
    end
    tick();
  endtask

  task automatic test_stall();
    bnd_t held;
    in_valid = 1; in_instr = {5'd9, 9'd3, 20'h12345 & 18'h3FFFF}; tick();
    held = got_b();
    in_instr = {5'd8, 9'd4, 9'd3, 9'd17}; out_ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL stall_ready[%0d]: got in_ready=%0b want 0", i, in_ready);
      end
      tick();
      nvec++;
      if (out_valid !== 1'b1 || got_b() !== held || got_b() !== e_b) begin
        nerr++;
        $display("FAIL stall_hold[%0d]: got v=%0b b=%h want 1 %h", i, out_valid, got_b(), held);
      end
    end
    out_ready = 1; #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL stall_release: got in_ready=%0b want 1", in_ready);
    end
    tick();
    in_valid = 0;
    nvec++;
    if (out_valid !== 1'b1 || got_b() !== e_b || out_opcode !== 5'd8) begin
      nerr++;
      $display("FAIL stall_next: got v=%0b b=%h want 1 %h", out_valid, got_b(), e_b);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL stall_nodup: got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] want;
    wb_en = 1; wb_idx = 5; wb_data = 2; tick();
    wb_data = 9;
    in_valid = 1; in_instr = {5'd2, 9'd6, 9'd5, 9'd5}; tick();
    wb_en = 0;
    want = bypass ? 32'd9 : 32'd2;
    nvec++;
    if (out_valid !== 1'b1 || out_rs_val !== want || out_rt_val !== want || got_b() !== e_b) begin
      nerr++;
      $display("FAIL bypass_same: got rs=%0d rt=%0d want %0d", out_rs_val, out_rt_val, want);
    end
    tick();
    in_valid = 0;
    nvec++;
    if (out_rs_val !== 32'd9 || out_rt_val !== 32'd9) begin
      nerr++;
      $display("FAIL bypass_next: got rs=%0d rt=%0d want 9", out_rs_val, out_rt_val);
    end
    tick();
  endtask

  task automatic test_flush();
    in_valid = 1; in_instr = {5'd6, 27'h1234567}; tick();
    out_ready = 0; in_instr = {5'd10, 27'h7654321}; flush = 1;
    wb_en = 1; wb_idx = 7; wb_data = 32'h77; tick();
    flush = 0; wb_en = 0; in_valid = 0;
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL flush_kill: got out_valid=%0b want 0", out_valid);
    end
    out_ready = 1; tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL flush_none: got out_valid=%0b want 0", out_valid);
    end
    in_valid = 1; in_instr = {5'd8, 9'd7, 9'd0, 9'd0}; tick();
    in_valid = 0;
    nvec++;
    if (out_rs_val !== 32'h77 || got_b() !== e_b) begin
      nerr++;
      $display("FAIL flush_wb: got rs=%h want 00000077", out_rs_val);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    in_valid = 1; in_instr = {5'd3, 9'd1, 9'd2, 9'd3}; tick();
    out_ready = 0; in_instr = {5'd4, 9'd2, 9'd3, 9'd1}; tick();
    #2 reset = 0;
    #1;
    model_clear();
    nvec++;
    if ({out_valid, got_b()} !== '0) begin
      nerr++;
      $display("FAIL reset_mid: got v=%0b b=%h want all zero", out_valid, got_b());
    end
    @(negedge clock);
    reset = 1; idle();
    @(posedge clock); #1;
    in_valid = 1; in_instr = {5'd8, 9'd7, 9'd5, 9'd0}; tick();
    nvec++;
    if (out_valid !== 1'b1 || out_rs_val !== 0 || out_rt_val !== 0) begin
      nerr++;
      $display("FAIL reset_regs_a: got rs=%h rt=%h want 0 0", out_rs_val, out_rt_val);
    end
    in_instr = {5'd2, 9'd0, 9'd3, 9'd4}; tick();
    in_valid = 0;
    nvec++;
    if (out_valid !== 1'b1 || out_rs_val !== 0 || out_rt_val !== 0) begin
      nerr++;
      $display("FAIL reset_regs_b: got rs=%h rt=%h want 0 0", out_rs_val, out_rt_val);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 16; i++) begin
      in_instr = $urandom;
      wb_en = 1'($urandom_range(0, 1)); wb_idx = IDX_W'($urandom); wb_data = $urandom;
      tick();
      if (out_valid === 1'b1) seen++;
      nvec++;
      if (out_valid !== 1'b1 || got_b() !== e_b) begin
        nerr++;
        $display("FAIL b2b[%0d]: got v=%0b b=%h want 1 %h", i, out_valid, got_b(), e_b);
      end
    end
    in_valid = 0; wb_en = 0; tick();
    nvec++;
    if (seen != 16 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_count: got %0d bundles, trailing v=%0b want 16 0", seen, out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = $urandom;
      if ($urandom_range(0, 1) == 1) in_instr[31:27] = 5'($urandom_range(1, 10));
      wb_en   = 1'($urandom_range(0, 1));
      wb_idx  = ($urandom_range(0, 1) == 1) ? in_instr[13:9] : IDX_W'($urandom);
      wb_data = $urandom;
      #1;
      nvec++;
      if (in_ready !== (!e_valid || out_ready)) begin
        nerr++;
        $display("FAIL rand_ready[%0d]: got %0b want %0b", i, in_ready, (!e_valid || out_ready));
      end
      tick();
      nvec++;
      if (out_valid !== e_valid || (e_valid && got_b() !== e_b)) begin
        nerr++;
        $display("FAIL rand_out[%0d]: got v=%0b b=%h want v=%0b b=%h", i, out_valid,
                 got_b(), e_valid, e_b);
      end
    end
    idle(); tick();
  endtask

  initial begin
`ifdef DECO_BYPASS_EN
    bypass = 1;
`else
    bypass = 0;
`endif
    test_reset();
    test_arith();
    test_lv_illegal();
    test_stall();
    test_bypass();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
